mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Multi-cycle access controller in the MEM stage, between the EXE/MEM pipeline register and the data memory.
- Takes one load/store request from the pipeline and holds the pipeline with `freeze` for a fixed number of wait states.
- Drives the memory's `mem_read`/`mem_write`/`address`/`data` for exactly one access cycle, then returns registered read data to the MEM/WB register.
- Lets the core model a slow memory without touching the memory itself.

Parameters:
- BASE_ADDR, 1024: byte address of memory word 0.
- DEPTH_WORDS, 64: number of 32-bit words behind the controller.
- WAIT_CYCLES, 3: extra BUSY cycles before the access cycle; legal range 0..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_read  in  1  load request from EXE/MEM, held stable while freeze=1
- req_write  in  1  store request from EXE/MEM, held stable while freeze=1
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- freeze  out  1  stall pipeline registers upstream of MEM/WB
- rdata  out  32  registered load result
- rdata_valid  out  1  one-cycle pulse, rdata updated for the current load
- addr_err  out  1  one-cycle error pulse; tied 0 without ADDR_CHECK_EN
- mem_read  out  1  to memory
- mem_write  out  1  to memory; memory writes on the rising edge while high
- mem_address  out  32  to memory, byte address
- mem_data  out  32  to memory, write data
- mem_result  in  32  from memory, combinational read data

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, counter=0, latched op/addr/data=0, rdata=0.
  - rdata_valid=0, addr_err=0.
  - rst is synchronous, but mem_write/mem_read are gated combinationally by !rst, so no access is issued in a reset cycle, including mid-operation.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - freeze = req_read|req_write (combinational).
  - On a request: latch op, req_addr, req_wdata; counter:=WAIT_CYCLES; go BUSY.
  - Both req_read and req_write high: treated as a write; no rdata_valid.
- BUSY:
  - freeze=1.
  - counter>0: decrement, stay.
  - counter==0 is the access cycle:
    - Write: mem_write=1 with mem_address/mem_data from the latches.
    - Read: mem_read=1, and rdata<=mem_result at the clock edge.
    - Go DONE.
- DONE:
  - freeze=0, so the pipeline advances at the end of this cycle.
  - rdata_valid=1 for reads.
  - Request inputs are ignored (still the old request); go IDLE.
- Latency: request first seen in IDLE at cycle 0; access cycle = WAIT_CYCLES+1; DONE = WAIT_CYCLES+2.
  - freeze is high for WAIT_CYCLES+2 cycles.
  - Back-to-back requests have one IDLE cycle between DONE and the next BUSY.
- Memory outputs outside the access cycle:
  - mem_read=0, mem_write=0.
  - mem_address and mem_data always show the latched values.
- rdata holds its value until the next completed read; writes do not change rdata.
- Address arithmetic:
  - No translation; mem_address = latched byte address.
  - The memory computes index = (addr-BASE_ADDR)>>2, and addr[1:0] is passed through.
- Counter width: max(1, clog2(WAIT_CYCLES+1)).

Optional Feature:
- Macro: MEM_ACCESS_CTRL_ADDR_CHECK_EN.
- With it: at request latch, flag as error if either holds:
  - addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS;
  - addr[1:0]!=0.
- Error access behaviour:
  - Same FSM timing, but no mem_read/mem_write is issued in the access cycle.
  - Reads load rdata:=0.
  - addr_err=1 in DONE.
- Without it: no checking; addr_err constant 0.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum {IDLE,BUSY,DONE};
  - constants WORD_W=32, default BASE_ADDR=1024, DEPTH_WORDS=64.
- One sub-module: wait_state_counter, a loadable down-counter with load, value and zero outputs.

Test Plan:
- WAIT_CYCLES=3, write 0xDEADBEEF to 1024:
  - freeze high 5 cycles;
  - mem_write high only in cycle 4 with address 1024, data 0xDEADBEEF.
  - Then read 1024 -> rdata=0xDEADBEEF, rdata_valid pulse in DONE.
- WAIT_CYCLES=0, write 0x12345678 to 1276, then read 1276:
  - each op has freeze high 2 cycles;
  - rdata=0x12345678.
- Back-to-back read 1024 then write 1028 (0xA5A5A5A5):
  - exactly one IDLE cycle between the ops;
  - mem_write never overlaps mem_read;
  - re-read 1028 returns 0xA5A5A5A5.
- Write 0x1 to 1028, then write 0xFF to 1028 with rst asserted in its access cycle:
  - mem_write=0 that cycle; state IDLE next; freeze=0 with no request;
  - controller-only reset, so a read of 1028 returns 0x1.
- req_read=req_write=1, addr 1032, data 5:
  - write performed, rdata_valid stays 0;
  - later read 1032 -> 5.
- With MEM_ACCESS_CTRL_ADDR_CHECK_EN:
  - write to 1280 -> no mem_write, addr_err pulse in DONE;
  - read 1026 -> addr_err pulse, rdata=0, rdata_valid=1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage multi-cycle access controller.
package mem_ctrl_pkg;

    localparam int unsigned WORD_W              = 32;
    localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Request captured from the EXE/MEM register when the controller accepts it.
    typedef struct packed {
        logic              is_write;
        logic              is_read;
        logic              err;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Width needed to hold the wait-state count, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/wait_state_counter.sv
// Loadable down-counter that paces the BUSY wait states; stops at zero.
module wait_state_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller that freezes the pipeline for WAIT_CYCLES wait states and
// issues a single memory access cycle. Optional range/alignment check: MEM_ACCESS_CTRL_ADDR_CHECK_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              freeze,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              addr_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data,
    input  logic [WORD_W-1:0] mem_result
);

    localparam int unsigned      CNT_W      = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(WAIT_CYCLES);
    localparam logic [WORD_W:0]  ADDR_BASE  = (WORD_W + 1)'(BASE_ADDR);
    localparam logic [WORD_W:0]  ADDR_LIMIT = (WORD_W + 1)'(BASE_ADDR) + (WORD_W + 1)'(4 * DEPTH_WORDS);

`ifdef MEM_ACCESS_CTRL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    state_t           state;
    state_t           state_nxt;
    mem_req_t         req_q;
    logic             latch_c;
    logic             access_c;
    logic             cnt_load_c;
    logic             cnt_dec_c;
    logic             mem_read_c;
    logic             mem_write_c;
    logic             addr_bad_c;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic [WORD_W:0]  addr_ext;

    wait_state_counter #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .dec      (cnt_dec_c),
        .load_val (CNT_INIT),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    // Out-of-window or misaligned byte address; only honoured with the check enabled.
    assign addr_ext   = {1'b0, req_addr};
    assign addr_bad_c = ADDR_CHECK &&
                        ((addr_ext < ADDR_BASE) || (addr_ext >= ADDR_LIMIT) || (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        freeze      = 1'b0;
        latch_c     = 1'b0;
        access_c    = 1'b0;
        cnt_load_c  = 1'b0;
        cnt_dec_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_read || req_write) begin
                    freeze     = 1'b1;
                    latch_c    = 1'b1;
                    cnt_load_c = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                freeze    = 1'b1;
                cnt_dec_c = (cnt_value != '0);
                if (cnt_zero) begin
                    access_c    = 1'b1;
                    mem_write_c = req_q.is_write && !req_q.err;
                    mem_read_c  = req_q.is_read && !req_q.err;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, load data capture and the DONE-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
            if (latch_c) begin
                req_q.is_write <= req_write;
                req_q.is_read  <= req_read && !req_write;
                req_q.err      <= addr_bad_c;
                req_q.addr     <= req_addr;
                req_q.wdata    <= req_wdata;
            end
            if (access_c) begin
                if (req_q.is_read) begin
                    rdata <= req_q.err ? '0 : mem_result;
                end
                rdata_valid <= req_q.is_read;
                addr_err    <= req_q.err;
            end
        end
    end

    // Strobes are masked by rst so a reset cycle never reaches the memory.
    assign mem_read    = mem_read_c && !rst;
    assign mem_write   = mem_write_c && !rst;
    assign mem_address = req_q.addr;
    assign mem_data    = req_q.wdata;

endmodule
